// File: rtl/button_conditioner.sv
// ============================================================================
// Module      : button_conditioner
// Description : Per-channel debounce, edge-detect and auto-repeat for
//               synchronized button inputs, driven by one shared sample timer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module button_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int REPEAT_DELAY   = 250,
  parameter int REPEAT_RATE    = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sync_in,
  input  logic             enable,
  output logic             sample_tick,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] repeat_pulse
);

  localparam int c_samp_w  = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int c_db_w    = (PULSE_CNT_MAX > 0) ? $clog2(PULSE_CNT_MAX + 1) : 1;
  localparam int c_rep_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_rep_w   = (c_rep_max > 0) ? $clog2(c_rep_max + 1) : 1;

  localparam logic [c_samp_w-1:0] c_samp_last = c_samp_w'(SAMPLE_CNT_MAX - 1);
  localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(PULSE_CNT_MAX - 1);
  localparam logic [c_rep_w-1:0]  c_rd_last   = c_rep_w'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [c_rep_w-1:0]  c_rr_last   = c_rep_w'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [c_samp_w-1:0] r_samp_cnt;
  logic [c_samp_w-1:0] w_samp_nxt;
  logic                r_tick;
  logic                w_adv;

  // Tick register is loaded from the next counter value so it is high in the
  // same cycle the counter sits at its terminal value.
  always_comb begin
    w_samp_nxt = r_samp_cnt;
    if (enable) begin
      w_samp_nxt = (r_samp_cnt == c_samp_last) ? '0 : r_samp_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_samp_cnt <= w_samp_nxt;
      r_tick     <= enable && (w_samp_nxt == c_samp_last);
    end
  end

  assign sample_tick = r_tick;
  assign w_adv       = r_tick & enable;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t             r_state,   w_state_nxt;
    logic [c_db_w-1:0]  r_db_cnt,  w_db_nxt;
    logic [c_rep_w-1:0] r_rep_cnt, w_rep_nxt;
    logic               r_deb,     w_deb_nxt;
    logic               r_press,   w_press;
    logic               r_rel,     w_rel;
    logic               r_rpt,     w_rpt;
    logic               w_flip;

    always_comb begin
      w_state_nxt = r_state;
      w_db_nxt    = r_db_cnt;
      w_rep_nxt   = r_rep_cnt;
      w_deb_nxt   = r_deb;
      w_press     = 1'b0;
      w_rel       = 1'b0;
      w_rpt       = 1'b0;
      w_flip      = 1'b0;
      if (w_adv) begin
        if (sync_in[i] == r_deb) begin
          w_db_nxt = '0;
        end else if (r_db_cnt == c_db_last) begin
          w_db_nxt = '0;
          w_flip   = 1'b1;
        end else begin
          w_db_nxt = r_db_cnt + 1'b1;
        end
        if (w_flip) begin
          w_deb_nxt = ~r_deb;
        end
        // A release always wins over a repeat falling due on the same tick.
        case (r_state)
          ST_IDLE: begin
            if (w_flip) begin
              w_state_nxt = ST_HELD;
              w_press     = 1'b1;
              w_rep_nxt   = '0;
            end
          end
          ST_HELD: begin
            if (w_flip) begin
              w_state_nxt = ST_IDLE;
              w_rel       = 1'b1;
              w_rep_nxt   = '0;
            end else if (REPEAT_DELAY != 0) begin
              if (r_rep_cnt == c_rd_last) begin
                w_state_nxt = ST_REPEAT;
                w_rpt       = 1'b1;
                w_rep_nxt   = '0;
              end else begin
                w_rep_nxt = r_rep_cnt + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (w_flip) begin
              w_state_nxt = ST_IDLE;
              w_rel       = 1'b1;
              w_rep_nxt   = '0;
            end else if (r_rep_cnt == c_rr_last) begin
              w_rpt     = 1'b1;
              w_rep_nxt = '0;
            end else begin
              w_rep_nxt = r_rep_cnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_rep_nxt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= ST_IDLE;
        r_db_cnt  <= '0;
        r_rep_cnt <= '0;
        r_deb     <= 1'b0;
        r_press   <= 1'b0;
        r_rel     <= 1'b0;
        r_rpt     <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_db_cnt  <= w_db_nxt;
        r_rep_cnt <= w_rep_nxt;
        r_deb     <= w_deb_nxt;
        r_press   <= w_press;
        r_rel     <= w_rel;
        r_rpt     <= w_rpt;
      end
    end

    assign debounced[i]     = r_deb;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_rel;
    assign repeat_pulse[i]  = r_rpt;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module      : tb_button_conditioner
// Description : Scoreboard bench for button_conditioner with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sync_in = 2'b00;
  logic       enable = 1'b1;
  logic       sample_tick;
  logic [1:0] debounced, press_pulse, release_pulse, repeat_pulse;

  button_conditioner #(
    .WIDTH(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .enable(enable),
    .sample_tick(sample_tick), .debounced(debounced), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  // Cycle k is the period following the k-th rising edge after reset release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [1:0] prs, rel, rpt, deb;
  } ev_t;

  ev_t  exp_q[$];
  int   tick_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic zchk = 1'b0;
  logic zseen = 1'b0;
  int   zkind = 0;

  task automatic push_ev(input int c, input logic [1:0] p, input logic [1:0] r,
                         input logic [1:0] rp, input logic [1:0] d);
    ev_t e;
    e.cyc = c; e.prs = p; e.rel = r; e.rpt = rp; e.deb = d;
    exp_q.push_back(e);
  endtask

  task automatic push_ticks(input int first, input int last);
    for (int t = first; t <= last; t += 4) tick_q.push_back(t);
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // kind 0: all outputs must be zero now; kind 1: scoreboard must be empty.
  task automatic request(input int kind);
    zkind = kind;
    zchk  = ~zchk;
    #1;
  endtask

  task automatic reset_release(input logic [1:0] s);
    rst_n   = 1'b0;
    sync_in = s;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    request(0);
  endtask

  initial begin
    ev_t e;
    int  t;
    forever begin
      @(negedge clk or zchk);
      if (zchk != zseen) begin
        zseen = zchk;
        n_cmp++;
        if (zkind == 0) begin
          if ({sample_tick, debounced, press_pulse, release_pulse, repeat_pulse} != 9'd0) begin
            n_fail++;
            $display("FAIL zero_outputs: tick=%b deb=%b press=%b rel=%b rpt=%b, required all 0",
                     sample_tick, debounced, press_pulse, release_pulse, repeat_pulse);
          end
        end else if (exp_q.size() != 0 || tick_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d events and %0d ticks outstanding, required 0 and 0",
                   exp_q.size(), tick_q.size());
          exp_q.delete();
          tick_q.delete();
        end
      end else if (rst_n) begin
        if (sample_tick) begin
          n_cmp++;
          if (tick_q.size() == 0) begin
            n_fail++;
            $display("FAIL tick: sample_tick at cycle %0d, required none", cyc);
          end else begin
            t = tick_q.pop_front();
            if (t != cyc) begin
              n_fail++;
              $display("FAIL tick: sample_tick at cycle %0d, required cycle %0d", cyc, t);
            end
          end
        end else if (tick_q.size() != 0 && tick_q[0] < cyc) begin
          n_cmp++;
          n_fail++;
          t = tick_q.pop_front();
          $display("FAIL tick: sample_tick missing at cycle %0d, required high then", t);
        end

        if ((press_pulse | release_pulse | repeat_pulse) != 2'b00) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: cycle %0d press=%b rel=%b rpt=%b, required no pulse",
                     cyc, press_pulse, release_pulse, repeat_pulse);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.prs != press_pulse || e.rel != release_pulse ||
                e.rpt != repeat_pulse || e.deb != debounced) begin
              n_fail++;
              $display("FAIL event: got cyc %0d press=%b rel=%b rpt=%b deb=%b, required cyc %0d press=%b rel=%b rpt=%b deb=%b",
                       cyc, press_pulse, release_pulse, repeat_pulse, debounced,
                       e.cyc, e.prs, e.rel, e.rpt, e.deb);
            end
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          n_cmp++;
          n_fail++;
          e = exp_q.pop_front();
          $display("FAIL event: nothing by cycle %0d, required press=%b rel=%b rpt=%b at cycle %0d",
                   cyc, e.prs, e.rel, e.rpt, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 ns, required finish");
    $fatal(1);
  end

  initial begin
    // Clean press on ch0, auto-repeat, then release landing on a due repeat.
    reset_release(2'b01);
    push_ticks(3, 67);
    push_ev(12, 2'b01, 2'b00, 2'b00, 2'b01);
    push_ev(32, 2'b00, 2'b00, 2'b01, 2'b01);
    push_ev(40, 2'b00, 2'b00, 2'b01, 2'b01);
    push_ev(48, 2'b00, 2'b00, 2'b01, 2'b01);
    push_ev(56, 2'b00, 2'b00, 2'b01, 2'b01);
    push_ev(64, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_cyc(52); sync_in = 2'b00;
    wait_cyc(70); request(1);

    // Bounce on ch0 (2 high, 1 low, then held); short glitches on ch1.
    reset_release(2'b01);
    push_ticks(3, 35);
    push_ev(24, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_cyc(8);  sync_in = 2'b00;
    wait_cyc(12); sync_in = 2'b11;
    wait_cyc(16); sync_in = 2'b01;
    wait_cyc(20); sync_in = 2'b11;
    wait_cyc(28); sync_in = 2'b01;
    wait_cyc(36); request(1);

    // Both channels pressed together, with a 10-cycle enable freeze mid-count.
    reset_release(2'b11);
    push_ticks(3, 3);
    push_ticks(17, 33);
    push_ev(22, 2'b11, 2'b00, 2'b00, 2'b11);
    wait_cyc(5);  enable = 1'b0;
    wait_cyc(15); enable = 1'b1;
    wait_cyc(36); request(1);

    // Asynchronous reset while repeating; no release may follow.
    reset_release(2'b01);
    push_ticks(3, 39);
    push_ev(12, 2'b01, 2'b00, 2'b00, 2'b01);
    push_ev(32, 2'b00, 2'b00, 2'b01, 2'b01);
    push_ev(40, 2'b00, 2'b00, 2'b01, 2'b01);
    wait_cyc(42); request(1);
    #1 rst_n = 1'b0;
    #1 request(0);
    reset_release(2'b00);
    push_ticks(3, 39);
    wait_cyc(40); request(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Per-channel debounce, edge-detect and auto-repeat controller for the already-synchronized button/switch inputs in the io_circuits path. It sits directly downstream of the 2-flop synchronizer bank and upstream of any consumer (UART CLI, LED/mode logic, CPU MMIO), turning raw bouncing levels into a clean level plus single-cycle press, release and repeat pulses. All channels share one sample timer; each channel runs an independent state machine.

## Interface
- WIDTH, 1, number of independent button channels
- SAMPLE_CNT_MAX, 62500, clk cycles per sample tick (must be ≥2)
- PULSE_CNT_MAX, 200, consecutive disagreeing samples required to flip the debounced level (≥1)
- REPEAT_DELAY, 250, sample ticks from press to first repeat pulse; 0 disables repeat
- REPEAT_RATE, 50, sample ticks between subsequent repeat pulses (≥1)
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- sync_in  input  WIDTH  synchronized button levels (1 = pressed)
- enable  input  1  1 = run; 0 = freeze all state, suppress pulses
- sample_tick  output  1  one-cycle strobe each sample period
- debounced  output  WIDTH  stable debounced level per channel
- press_pulse  output  WIDTH  one-cycle pulse on debounced 0→1
- release_pulse  output  WIDTH  one-cycle pulse on debounced 1→0
- repeat_pulse  output  WIDTH  one-cycle pulse per auto-repeat event while held

## Operation
- Reset (rst_n low, asynchronous): sample counter 0, all channel counters 0, all FSMs IDLE; every output 0.
- Sample timer: counter 0..SAMPLE_CNT_MAX-1, width $clog2(SAMPLE_CNT_MAX); sample_tick = 1 (registered) in the cycle the counter equals SAMPLE_CNT_MAX-1, then wraps to 0.
- enable=0: sample counter holds, no sample_tick, all channel state holds, pulse outputs 0; debounced holds value.
- Per-channel debounce counter (width $clog2(PULSE_CNT_MAX+1)), updated only on sample_tick:
  - sync_in == debounced → counter cleared.
  - sync_in != debounced → counter +1; on reaching PULSE_CNT_MAX, debounced flips and counter clears.
- Per-channel FSM (advances only on sample_tick), repeat counter counts ticks:
  - IDLE (debounced 0): debounce flip to 1 → HELD, press_pulse, repeat counter 0.
  - HELD: flip to 0 → IDLE, release_pulse. Else if REPEAT_DELAY≠0, counter +1; on reaching REPEAT_DELAY → REPEAT, repeat_pulse, counter 0.
  - REPEAT: flip to 0 → IDLE, release_pulse. Else counter +1; on reaching REPEAT_RATE → repeat_pulse, counter 0.
  - Release and repeat due on same tick: release only, no repeat_pulse.
- Channels fully independent; simultaneous events on different channels all reported in the same cycle.
- No pulses asserted without a preceding sample_tick; all pulses exactly one cycle wide.

## Timing
- All outputs registered. debounced, press/release/repeat pulses update on the clk edge that ends the sample_tick cycle; pulses visible the following cycle only.
- Press latency from a stable change: PULSE_CNT_MAX sample ticks (first counted tick is the first tick after change) + 1 cycle.
- First repeat_pulse REPEAT_DELAY ticks after press_pulse; subsequent every REPEAT_RATE ticks (= REPEAT_RATE·SAMPLE_CNT_MAX cycles).
- rst_n asserted mid-count or mid-repeat: immediate clear to reset values, no release_pulse generated; after deassertion, sample counter starts at 0 on the first clk edge.
- A single disagreeing sample followed by an agreeing one restarts the count (glitch shorter than PULSE_CNT_MAX ticks never flips debounced).

## Test plan
Parameters for all: WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, REPEAT_DELAY=5, REPEAT_RATE=2.
- Reset/tick: release rst_n, enable=1, sync_in=0 → all outputs 0; sample_tick high at cycles 3,7,11,… exactly one cycle each.
- Clean press: sync_in[0]=1 from cycle 0 → debounced[0] and press_pulse[0] rise after the 3rd tick (cycle 12), press_pulse low at cycle 13; channel 1 untouched.
- Bounce: sync_in[0] high for 2 ticks, low for 1, high for 2 → no press; held high thereafter → press after 3 further consecutive ticks.
- Auto-repeat: hold channel 0 → repeat_pulse 5 ticks (20 cycles) after press, then every 2 ticks (8 cycles); drop sync_in on a tick where repeat is due → release_pulse only after 3 low ticks, no repeat that cycle.
- Enable/simultaneous: both channels pressed same cycle → both press_pulses same cycle; enable=0 mid-count for 10 cycles → no ticks, counts/debounced frozen, resume exactly where left.
- Async reset mid-repeat: pull rst_n low between clk edges while in REPEAT → outputs 0 immediately, no release_pulse after deassertion with sync_in=0.
